// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl - central sequencer for the 5-stage MIPS pipeline.
//
// Arbitrates the per-cycle stall/flush causes (data-memory wait, branch
// mispredict, load-use hazard, instruction-cache miss), sequences the halt
// (RUN -> DRAIN -> HALTED) and keeps stall / flush performance counters.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   ihit                 instruction fetch returned this cycle
//   dreq, dhit           MEM-stage access outstanding / completed
//   mispredict           EX-stage branch resolved against its prediction
//   loaduse              ID-stage instruction depends on a load in EX
//   halt_id              HALT decoded in ID
//   pc_en                PC load enable
//   ifid_en .. memwb_en  pipe register enables
//   ifid_flush, idex_flush  pipe register synchronous clears
//   halt_o               processor halted (sticky until nRST)
//   stall_cnt            cycles with pc_en=0 outside HALTED
//   flush_cnt            mispredict flush events
//
// Control outputs are combinational from the current state and inputs, and
// are forced low while nRST is asserted.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int CNT_W = 32,
    parameter int DRAIN = 3
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dreq,
    input  logic             dhit,
    input  logic             mispredict,
    input  logic             loaduse,
    input  logic             halt_id,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halt_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [DW-1:0]    DCNT_LOAD = DW'(DRAIN - 1);
    localparam logic [DW-1:0]    DCNT_ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]    DCNT_ZERO = {DW{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [DW-1:0] dcnt_r, dcnt_nxt_s;

    logic freeze_s;
    logic flush_evt_s;
    logic pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s;
    logic ifid_flush_s, idex_flush_s;

    assign freeze_s = dreq & ~dhit;

    // State and drain counter register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_RUN;
            dcnt_r  <= DCNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            dcnt_r  <= dcnt_nxt_s;
        end
    end

    // Next-state decode and per-cycle pipeline control
    always_comb begin
        state_nxt_s  = state_r;
        dcnt_nxt_s   = dcnt_r;
        flush_evt_s  = 1'b0;
        pc_en_s      = 1'b0;
        ifid_en_s    = 1'b0;
        idex_en_s    = 1'b0;
        exmem_en_s   = 1'b0;
        memwb_en_s   = 1'b0;
        ifid_flush_s = 1'b0;
        idex_flush_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (freeze_s) begin
                    // Whole pipe holds while data memory is busy.
                    pc_en_s = 1'b0;
                end else if (mispredict) begin
                    // Squash IF and ID; any halt in ID is on the wrong path.
                    pc_en_s      = 1'b1;
                    ifid_en_s    = 1'b1;
                    idex_en_s    = 1'b1;
                    exmem_en_s   = 1'b1;
                    memwb_en_s   = 1'b1;
                    ifid_flush_s = 1'b1;
                    idex_flush_s = 1'b1;
                    flush_evt_s  = 1'b1;
                end else if (halt_id) begin
                    // Drain entry: stop fetching, let HALT and older retire.
                    pc_en_s      = 1'b0;
                    ifid_flush_s = 1'b1;
                    idex_en_s    = 1'b1;
                    exmem_en_s   = 1'b1;
                    memwb_en_s   = 1'b1;
                    state_nxt_s  = ST_DRAIN;
                    dcnt_nxt_s   = DCNT_LOAD;
                end else if (loaduse) begin
                    // Hold IF/ID, bubble into EX.
                    idex_flush_s = 1'b1;
                    exmem_en_s   = 1'b1;
                    memwb_en_s   = 1'b1;
                end else if (!ihit) begin
                    // Fetch miss: bubble into ID.
                    ifid_flush_s = 1'b1;
                    idex_en_s    = 1'b1;
                    exmem_en_s   = 1'b1;
                    memwb_en_s   = 1'b1;
                end else begin
                    pc_en_s    = 1'b1;
                    ifid_en_s  = 1'b1;
                    idex_en_s  = 1'b1;
                    exmem_en_s = 1'b1;
                    memwb_en_s = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Younger slots are already bubbles, so mispredict/loaduse are moot.
                pc_en_s      = 1'b0;
                ifid_flush_s = 1'b1;
                idex_en_s    = ~freeze_s;
                exmem_en_s   = ~freeze_s;
                memwb_en_s   = ~freeze_s;
                if (freeze_s) begin
                    dcnt_nxt_s = dcnt_r;
                end else if (dcnt_r == DCNT_ZERO) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    dcnt_nxt_s = dcnt_r - DCNT_ONE;
                end
            end
            ST_HALTED: begin
                state_nxt_s = ST_HALTED;
            end
            default: begin
                // Unreachable encoding: recover to a known state.
                state_nxt_s = ST_RUN;
                dcnt_nxt_s  = DCNT_ZERO;
            end
        endcase
    end

    // Performance counters (wrap naturally)
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= CNT_ZERO;
            flush_cnt <= CNT_ZERO;
        end else begin
            if (!pc_en_s && (state_r != ST_HALTED)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_evt_s) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

    assign pc_en      = pc_en_s      & nRST;
    assign ifid_en    = ifid_en_s    & nRST;
    assign idex_en    = idex_en_s    & nRST;
    assign exmem_en   = exmem_en_s   & nRST;
    assign memwb_en   = memwb_en_s   & nRST;
    assign ifid_flush = ifid_flush_s & nRST;
    assign idex_flush = idex_flush_s & nRST;
    assign halt_o     = (state_r == ST_HALTED);

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl - directed self-checking bench for pipe_ctrl.
// Each step drives inputs and pushes the expected control vector
// {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt_o}
// onto a scoreboard queue; the vector is popped and compared mid-cycle.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dreq, dhit, mispredict, loaduse, halt_id;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, halt_o;
    logic [31:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] NORM = 8'b1111_1000;
    localparam logic [7:0] FRZ  = 8'b0000_0000;
    localparam logic [7:0] MISP = 8'b1111_1110;
    localparam logic [7:0] LU   = 8'b0001_1010;
    localparam logic [7:0] MISS = 8'b0011_1100;
    localparam logic [7:0] DRN  = 8'b0011_1100;
    localparam logic [7:0] DRNF = 8'b0000_0100;
    localparam logic [7:0] HLT  = 8'b0000_0001;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;
    sb_t sb_q[$];

    pipe_ctrl #(.CNT_W(32), .DRAIN(3)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ihit       (ihit),
        .dreq       (dreq),
        .dhit       (dhit),
        .mispredict (mispredict),
        .loaduse    (loaduse),
        .halt_id    (halt_id),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .idex_en    (idex_en),
        .exmem_en   (exmem_en),
        .memwb_en   (memwb_en),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .halt_o     (halt_o),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic i_ihit, input logic i_dreq, input logic i_dhit,
                         input logic i_misp, input logic i_lu, input logic i_halt);
        ihit       = i_ihit;
        dreq       = i_dreq;
        dhit       = i_dhit;
        mispredict = i_misp;
        loaduse    = i_lu;
        halt_id    = i_halt;
    endtask

    // Called 1 time unit after a rising edge with inputs already driven.
    task automatic cyc(input string tag, input logic [7:0] exp);
        sb_t e;
        sb_t got;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        #3;
        got = sb_q.pop_front();
        check(got.tag,
              {24'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt_o},
              {24'd0, got.exp});
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] s, input logic [31:0] f);
        check({tag, "_stall"}, stall_cnt, s);
        check({tag, "_flush"}, flush_cnt, f);
    endtask

    initial begin
        // Reset with a fetch hit present: outputs must still be forced low.
        nRST = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst_ctrl", {24'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt_o}, 32'd0);
        chk_cnt("rst", 32'd0, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Normal flow
        for (int i = 0; i < 5; i++) cyc("norm", NORM);
        chk_cnt("norm", 32'd0, 32'd0);

        // Data freeze with a mispredict held throughout
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("freeze", FRZ);
        chk_cnt("freeze", 32'd4, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("release_misp", MISP);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("after_release", NORM);
        chk_cnt("release", 32'd4, 32'd1);

        // Load-use bubble
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("loaduse", LU);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("after_lu", NORM);
        chk_cnt("loaduse", 32'd5, 32'd1);

        // Mispredict beats loaduse and fetch miss
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("misp_lu_miss", MISP);
        chk_cnt("misp_prio", 32'd5, 32'd2);

        // Fetch miss alone
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("imiss", MISS);
        chk_cnt("imiss", 32'd6, 32'd2);

        // Halt on the wrong path is discarded
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("halt_misp", MISP);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("halt_discard", NORM);
        chk_cnt("halt_misp", 32'd6, 32'd3);

        // Halt: entry cycle, three DRAIN cycles, then sticky HALTED
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("drain_entry", DRN);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("drain", DRN);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc("halted1", HLT);
        cyc("halted2", HLT);
        chk_cnt("halted", 32'd10, 32'd3);

        // Asynchronous reset while HALTED, checked between clock edges
        #2;
        nRST = 1'b0;
        #1;
        check("async_halt", {31'd0, halt_o}, 32'd0);
        chk_cnt("async", 32'd0, 32'd0);
        check("async_pc_en", {31'd0, pc_en}, 32'd0);
        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        cyc("post_rst", NORM);

        // Halt with a 2-cycle data freeze inside DRAIN
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("drain2_entry", DRN);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("drain2_misp_ignored", DRN);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("drain2_frz1", DRNF);
        cyc("drain2_frz2", DRNF);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("drain2_a", DRN);
        cyc("drain2_b", DRN);
        cyc("drain2_halted", HLT);
        chk_cnt("drain2", 32'd6, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
